// File: rtl/ysyx_22050019_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_ifu -- instruction fetch unit
//
// Purpose:
//   Fetches 32-bit instructions from an 8-byte-wide icache, one request and
//   one response at a time, and hands them to decode with a valid/ready
//   handshake. Redirects (branch/jump/trap) take priority over every other
//   event. If a redirect arrives while an icache transaction is in flight,
//   that transaction is allowed to finish (the icache cannot abort) and its
//   data is thrown away.
//
// Optional feature:
//   `define YSYX_22050019_IFU_LINE_REUSE_EN
//     After decode accepts the lower word of a fetched line, the upper word
//     of the same line is presented on the next cycle without a new icache
//     request. Reuse is skipped when the line returned an error response.
//   Without the macro every instruction costs one icache transaction.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   ar_valid_o/ar_ready_i        fetch request handshake
//   ar_addr_o                    8-byte-aligned fetch address
//   r_data_valid_i/r_data_ready_o  fetch response handshake
//   r_resp_i                     response code, 0 = OK
//   r_data_i                     8-byte fetch line
//   redirect_valid_i/redirect_pc_i  new PC from branch/jump/trap
//   inst_valid_o/inst_ready_i    instruction handshake to decode
//   inst_o, pc_o, inst_err_o     instruction, its PC, fetch-error flag
// ---------------------------------------------------------------------------
module ysyx_22050019_ifu #(
   parameter int                    ADDR_WIDTH = 64,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h8000_0000,
   parameter int                    DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  ar_valid_o,
   input  logic                  ar_ready_i,
   output logic [ADDR_WIDTH-1:0] ar_addr_o,
   input  logic                  r_data_valid_i,
   output logic                  r_data_ready_o,
   input  logic [1:0]            r_resp_i,
   input  logic [DATA_WIDTH-1:0] r_data_i,
   input  logic                  redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  inst_valid_o,
   input  logic                  inst_ready_i,
   output logic [31:0]           inst_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  inst_err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_OUT
   } state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] pc, pc_n;
   logic [ADDR_WIDTH-1:0] ar_addr, ar_addr_n;
   logic [ADDR_WIDTH-1:0] pc_out, pc_out_n;
   logic [31:0]           inst, inst_n;
   logic                  inst_err, inst_err_n;
   logic                  kill, kill_n;
`ifdef YSYX_22050019_IFU_LINE_REUSE_EN
   logic [31:0]           line_hi, line_hi_n;
   logic                  line_valid, line_valid_n;
`endif

   logic [ADDR_WIDTH-1:0] redirect_tgt;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [31:0]           line_word;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  inst_hs;

   // Fetch addresses always point at the 8-byte line holding the PC.
   function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [ADDR_WIDTH-1:0] p);
      return {p[ADDR_WIDTH-1:3], 3'b000};
   endfunction

   // Handshake and output decode come straight from the state so that the
   // request and the instruction stay stable while the other side stalls.
   assign ar_valid_o     = (state == S_AR);
   assign r_data_ready_o = (state == S_R);
   assign inst_valid_o   = (state == S_OUT);
   assign ar_addr_o      = ar_addr;
   assign inst_o         = inst;
   assign pc_o           = pc_out;
   assign inst_err_o     = inst_err;

   assign ar_hs        = ar_valid_o & ar_ready_i;
   assign r_hs         = r_data_valid_i & r_data_ready_o;
   assign inst_hs      = inst_valid_o & inst_ready_i;
   assign redirect_tgt = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
   assign pc_inc       = pc + ADDR_WIDTH'(4);
   assign line_word    = pc[2] ? r_data_i[63:32] : r_data_i[31:0];

   // All architectural state lives here; reset abandons any transaction in
   // flight, which is safe because the icache shares the same reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         ar_addr  <= '0;
         pc_out   <= '0;
         inst     <= '0;
         inst_err <= 1'b0;
         kill     <= 1'b0;
`ifdef YSYX_22050019_IFU_LINE_REUSE_EN
         line_hi    <= '0;
         line_valid <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         ar_addr  <= ar_addr_n;
         pc_out   <= pc_out_n;
         inst     <= inst_n;
         inst_err <= inst_err_n;
         kill     <= kill_n;
`ifdef YSYX_22050019_IFU_LINE_REUSE_EN
         line_hi    <= line_hi_n;
         line_valid <= line_valid_n;
`endif
      end
   end

   // Next-state logic. A redirect always updates the PC first; the state
   // arms then decide what happens to the work in progress. The request
   // address is only loaded on the way into S_AR, so a redirect arriving
   // while a request waits for ar_ready_i cannot disturb that request.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      ar_addr_n  = ar_addr;
      pc_out_n   = pc_out;
      inst_n     = inst;
      inst_err_n = inst_err;
      kill_n     = kill;
`ifdef YSYX_22050019_IFU_LINE_REUSE_EN
      line_hi_n    = line_hi;
      line_valid_n = line_valid;
`endif

      if (redirect_valid_i) begin
         pc_n = redirect_tgt;
      end

      case (state)
         S_IDLE: begin
            state_n   = S_AR;
            ar_addr_n = line_addr(pc_n);
         end

         S_AR: begin
            // The request is already visible to the icache; remember that
            // its response must be dropped.
            if (redirect_valid_i) begin
               kill_n = 1'b1;
            end
            if (ar_hs) begin
               state_n = S_R;
            end
         end

         S_R: begin
            if (r_hs) begin
               if (kill || redirect_valid_i) begin
                  // Stale line: drop it and fetch from the updated PC.
                  kill_n    = 1'b0;
                  state_n   = S_AR;
                  ar_addr_n = line_addr(pc_n);
`ifdef YSYX_22050019_IFU_LINE_REUSE_EN
                  line_valid_n = 1'b0;
`endif
               end else begin
                  inst_n     = line_word;
                  pc_out_n   = pc;
                  inst_err_n = (r_resp_i != 2'b00);
                  state_n    = S_OUT;
`ifdef YSYX_22050019_IFU_LINE_REUSE_EN
                  line_hi_n    = r_data_i[63:32];
                  line_valid_n = 1'b1;
`endif
               end
            end else if (redirect_valid_i) begin
               kill_n = 1'b1;
            end
         end

         S_OUT: begin
            // A redirect wins over pc+4 even when decode takes the current
            // instruction in the same cycle.
            if (redirect_valid_i) begin
               state_n   = S_AR;
               ar_addr_n = line_addr(pc_n);
`ifdef YSYX_22050019_IFU_LINE_REUSE_EN
               line_valid_n = 1'b0;
`endif
            end else if (inst_hs) begin
               pc_n = pc_inc;
`ifdef YSYX_22050019_IFU_LINE_REUSE_EN
               if (!pc[2] && !inst_err && line_valid) begin
                  inst_n   = line_hi;
                  pc_out_n = pc_inc;
               end else begin
                  state_n      = S_AR;
                  ar_addr_n    = line_addr(pc_inc);
                  line_valid_n = 1'b0;
               end
`else
               state_n   = S_AR;
               ar_addr_n = line_addr(pc_inc);
`endif
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050019_ifu -- self-checking bench for ysyx_22050019_ifu
//
// A behavioural icache (one outstanding request, programmable latency)
// feeds the IFU. An architectural PC model tracks which instruction decode
// should receive next: pc+4 on every accepted instruction, redirect target
// on every redirect. Every accepted instruction is compared with the model.
// ---------------------------------------------------------------------------
module tb_ysyx_22050019_ifu;

   localparam logic [63:0] RESET_PC = 64'h8000_0000;

   logic        clk;
   logic        rst_n;
   logic        ar_valid_o;
   logic        ar_ready_i;
   logic [63:0] ar_addr_o;
   logic        r_data_valid_i;
   logic        r_data_ready_o;
   logic [1:0]  r_resp_i;
   logic [63:0] r_data_i;
   logic        redirect_valid_i;
   logic [63:0] redirect_pc_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [63:0] pc_o;
   logic        inst_err_o;

   int checkCount = 0;
   int errorCount = 0;
   int instCount  = 0;

   logic [63:0] modelPc;
   bit          pend;
   logic [63:0] pendAddr;
   int          pendCnt;
   bit          prevArWait;
   logic [63:0] prevArAddr;
   bit          prevInstWait;
   logic [31:0] prevInst;
   logic [63:0] prevPc;
   logic        prevErr;

   ysyx_22050019_ifu #(
      .ADDR_WIDTH(64),
      .RESET_PC  (RESET_PC),
      .DATA_WIDTH(64)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ar_valid_o      (ar_valid_o),
      .ar_ready_i      (ar_ready_i),
      .ar_addr_o       (ar_addr_o),
      .r_data_valid_i  (r_data_valid_i),
      .r_data_ready_o  (r_data_ready_o),
      .r_resp_i        (r_resp_i),
      .r_data_i        (r_data_i),
      .redirect_valid_i(redirect_valid_i),
      .redirect_pc_i   (redirect_pc_i),
      .inst_valid_o    (inst_valid_o),
      .inst_ready_i    (inst_ready_i),
      .inst_o          (inst_o),
      .pc_o            (pc_o),
      .inst_err_o      (inst_err_o)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Icache contents: one fixed line at the reset vector, a hash elsewhere.
   function automatic logic [63:0] memLine(input logic [63:0] a);
      if (a == 64'h8000_0000) return 64'h00000013_00100093;
      return {a[31:0] ^ 32'h1357_9BDF, ~a[31:0] + 32'h0246_8ACE};
   endfunction

   // Lines whose address bits [6:3] are 4'b1011 answer with an error code.
   function automatic logic [1:0] respOf(input logic [63:0] a);
      return (a[6:3] == 4'b1011) ? 2'b10 : 2'b00;
   endfunction

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic driveIdle();
      ar_ready_i       = 1'b0;
      r_data_valid_i   = 1'b0;
      r_resp_i         = 2'b00;
      r_data_i         = '0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
      inst_ready_i     = 1'b0;
   endtask

   task automatic clearBenchState();
      modelPc      = RESET_PC;
      pend         = 0;
      pendAddr     = '0;
      pendCnt      = 0;
      prevArWait   = 0;
      prevInstWait = 0;
   endtask

   // One clock cycle, entered and left at a negative edge. Drives inputs,
   // predicts handshakes, updates the icache and PC models, checks.
   task automatic applyStimulus(input bit arRdy, input bit instRdy, input bit redir,
                                input logic [63:0] redirPc, input int lat);
      bit          arHs;
      bit          rHs;
      bit          instHs;
      logic [63:0] la;
      logic [63:0] ln;
      if (prevArWait) begin
         checkOutput("ar_hold_valid", ar_valid_o, 1);
         checkOutput("ar_hold_addr", ar_addr_o, prevArAddr);
      end
      if (prevInstWait) begin
         checkOutput("inst_hold_valid", inst_valid_o, 1);
         checkOutput("inst_hold_inst", inst_o, prevInst);
         checkOutput("inst_hold_pc", pc_o, prevPc);
         checkOutput("inst_hold_err", inst_err_o, prevErr);
      end
      r_data_valid_i = pend && (pendCnt == 0);
      r_data_i       = memLine(pendAddr);
      r_resp_i       = respOf(pendAddr);
      if (pend && pendCnt != 0) pendCnt--;
      ar_ready_i       = arRdy;
      inst_ready_i     = instRdy;
      redirect_valid_i = redir;
      redirect_pc_i    = redirPc;
      arHs   = ar_valid_o && arRdy;
      rHs    = r_data_valid_i && r_data_ready_o;
      instHs = inst_valid_o && instRdy;
      if (instHs) begin
         la = {modelPc[63:3], 3'b000};
         ln = memLine(la);
         checkOutput("pc_o", pc_o, modelPc);
         checkOutput("inst_o", inst_o, modelPc[2] ? ln[63:32] : ln[31:0]);
         checkOutput("inst_err_o", inst_err_o, respOf(la) != 2'b00);
         modelPc = modelPc + 64'd4;
         instCount++;
      end
      if (redir) modelPc = {redirPc[63:2], 2'b00};
      if (rHs) pend = 0;
      if (arHs) begin
         checkOutput("single_outstanding", pend, 0);
         checkOutput("ar_aligned", ar_addr_o[2:0], 0);
         pend     = 1;
         pendAddr = ar_addr_o;
         pendCnt  = lat;
      end
      prevArWait   = ar_valid_o && !arRdy;
      prevArAddr   = ar_addr_o;
      prevInstWait = inst_valid_o && !instRdy && !redir;
      prevInst     = inst_o;
      prevPc       = pc_o;
      prevErr      = inst_err_o;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs with an always-ready icache until an instruction is presented.
   task automatic drainToValid();
      for (int i = 0; i < 60; i++) begin
         if (inst_valid_o) break;
         applyStimulus(1, 0, 0, '0, 0);
      end
      checkOutput("drain_valid", inst_valid_o, 1);
   endtask

   // Directed scenarios first, then a long randomized run.
   initial begin
      int lastCount;
      int quiet;
      driveIdle();
      clearBenchState();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_outputs",
                  {ar_valid_o, r_data_ready_o, inst_valid_o, inst_err_o}, 0);
      checkOutput("rst_ar_addr", ar_addr_o, 0);
      checkOutput("rst_inst", inst_o, 0);
      checkOutput("rst_pc_o", pc_o, 0);
      rst_n = 1'b1;
      checkOutput("idle_no_req", ar_valid_o, 0);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("first_ar_valid", ar_valid_o, 1);
      checkOutput("first_ar_addr", ar_addr_o, 64'h8000_0000);
      applyStimulus(1, 0, 0, '0, 0);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("first_valid", inst_valid_o, 1);
      checkOutput("first_inst", inst_o, 32'h0010_0093);
      checkOutput("first_pc", pc_o, 64'h8000_0000);

      // Decode stalls; the hold checks run inside every cycle.
      repeat (5) applyStimulus(0, 0, 0, '0, 0);
      checkOutput("stall_pc", pc_o, 64'h8000_0000);
      applyStimulus(0, 1, 0, '0, 0);
`ifdef YSYX_22050019_IFU_LINE_REUSE_EN
      checkOutput("reuse_valid", inst_valid_o, 1);
      checkOutput("reuse_no_req", ar_valid_o, 0);
      checkOutput("reuse_inst", inst_o, 32'h0000_0013);
      checkOutput("reuse_pc", pc_o, 64'h8000_0004);
`else
      checkOutput("second_req", ar_valid_o, 1);
      checkOutput("second_addr", ar_addr_o, 64'h8000_0000);
      checkOutput("second_no_valid", inst_valid_o, 0);
`endif
      drainToValid();
      applyStimulus(0, 1, 0, '0, 0);

      // Redirect while the response is outstanding.
      applyStimulus(1, 0, 0, '0, 3);
      checkOutput("in_r_state", r_data_ready_o, 1);
      applyStimulus(0, 0, 1, 64'h8000_1006, 0);
      for (int i = 0; i < 10; i++) begin
         if (ar_valid_o) break;
         checkOutput("killed_no_valid", inst_valid_o, 0);
         applyStimulus(0, 0, 0, '0, 0);
      end
      checkOutput("redir_ar_addr", ar_addr_o, 64'h8000_1000);
      drainToValid();
      checkOutput("redir_pc_o", pc_o, 64'h8000_1004);
      applyStimulus(0, 1, 0, '0, 0);

      // Redirect together with an instruction handshake.
      drainToValid();
      applyStimulus(0, 1, 1, 64'h8000_2000, 0);
      checkOutput("hs_redir_req", ar_valid_o, 1);
      checkOutput("hs_redir_addr", ar_addr_o, 64'h8000_2000);
      checkOutput("hs_redir_drop", inst_valid_o, 0);
      drainToValid();
      checkOutput("hs_redir_pc", pc_o, 64'h8000_2000);

      // Error response: flagged, and never reused.
      applyStimulus(0, 0, 1, 64'h8000_0058, 0);
      drainToValid();
      checkOutput("err_flag", inst_err_o, 1);
      checkOutput("err_pc", pc_o, 64'h8000_0058);
      applyStimulus(0, 1, 0, '0, 0);
      checkOutput("err_no_reuse", inst_valid_o, 0);
      drainToValid();
      checkOutput("err_upper_pc", pc_o, 64'h8000_005C);
      applyStimulus(0, 1, 0, '0, 0);

      // Reset in the middle of a response.
      applyStimulus(1, 0, 0, '0, 5);
      checkOutput("pre_rst_in_r", r_data_ready_o, 1);
      #2;
      rst_n = 1'b0;
      driveIdle();
      #1;
      checkOutput("async_rst_outputs",
                  {ar_valid_o, r_data_ready_o, inst_valid_o, inst_err_o}, 0);
      checkOutput("async_rst_addr", ar_addr_o, 0);
      checkOutput("async_rst_pc_o", pc_o, 0);
      clearBenchState();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("post_rst_req", ar_valid_o, 1);
      checkOutput("post_rst_addr", ar_addr_o, 64'h8000_0000);

      // Randomized traffic against the architectural PC model.
      lastCount = instCount;
      quiet     = 0;
      for (int c = 0; c < 4000; c++) begin
         logic [63:0] tgt;
         tgt = 64'h8000_0000 | 64'($urandom & 32'h0000_03FE);
         applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6,
                       $urandom_range(0, 99) < 4, tgt, $urandom_range(0, 3));
         if (instCount != lastCount) begin
            lastCount = instCount;
            quiet     = 0;
         end else begin
            quiet++;
            if (quiet > 300) begin
               checkOutput("liveness", 0, 1);
               quiet = 0;
            end
         end
      end
      checkOutput("progress", instCount > 400, 1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
